// File: rtl/echo_delay_line.sv
// Echo/comb processor: a circular delay buffer feeds a power-of-two scaled echo back into the sample path.
// Optional ECHO_SAT_EN clamps the mixed result; when it is undefined the result wraps in two's complement.
module echo_delay_line #(
  parameter int DW          = 10,
  parameter int AW          = 13,
  parameter int DELAY_SHIFT = 3
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic [DW-1:0]             data_in,
  input  logic                      data_valid,
  input  logic [AW-DELAY_SHIFT-1:0] delay_sel,
  input  logic [1:0]                mode,
  input  logic [1:0]                gain_shift,
  output logic [DW-1:0]             data_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  typedef enum logic [1:0] {CLEAR, IDLE, READ, CALC} state_t;

  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          dv_q, dv_d, dv_prev_q, dv_prev_d;
  logic signed [DW-1:0] x_q, x_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    gain_q, gain_d;
  logic          dly_zero_q, dly_zero_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  logic signed [DW-1:0] mem_rdata;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic signed [DW-1:0] mem_wdata;

  logic                 edge_seen;
  logic [AW-1:0]        dly;
  logic [2:0]           shamt;
  logic signed [DW-1:0] echo;
  logic signed [DW:0]   x_ext, echo_ext, sum;
  logic signed [DW-1:0] y;

  assign edge_seen = dv_q & ~dv_prev_q;
  assign dly       = {delay_sel, {DELAY_SHIFT{1'b0}}};
  assign shamt     = {1'b0, gain_q} + 3'd1;

  // Mixing datapath, only consumed in CALC.
  always_comb begin
    echo     = mem_rdata >>> shamt;
    x_ext    = {x_q[DW-1], x_q};
    echo_ext = {echo[DW-1], echo};
    sum      = x_ext;
    if (!dly_zero_q) begin
      case (mode_q)
        2'b01, 2'b11: sum = x_ext + echo_ext;
        2'b10:        sum = x_ext - echo_ext;
        default:      sum = x_ext;
      endcase
    end
`ifdef ECHO_SAT_EN
    if (sum[DW] == 1'b0 && sum[DW-1] == 1'b1)
      y = {1'b0, {(DW-1){1'b1}}};
    else if (sum[DW] == 1'b1 && sum[DW-1] == 1'b0)
      y = {1'b1, {(DW-1){1'b0}}};
    else
      y = sum[DW-1:0];
`else
    y = sum[DW-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_addr_d   = rd_addr_q;
    clr_addr_d  = clr_addr_q;
    dv_d        = data_valid;
    dv_prev_d   = dv_q;
    x_d         = x_q;
    mode_d      = mode_q;
    gain_d      = gain_q;
    dly_zero_d  = dly_zero_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata   = x_q;

    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (edge_seen) begin
          x_d        = {~data_in[DW-1], data_in[DW-2:0]};
          mode_d     = mode;
          gain_d     = gain_shift;
          dly_zero_d = (delay_sel == '0);
          rd_addr_d  = wr_ptr_q - dly;
          state_d    = READ;
        end
      end
      READ: begin
        if (edge_seen) overrun_d = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (edge_seen) overrun_d = 1'b1;
        mem_we      = 1'b1;
        mem_waddr   = wr_ptr_q;
        // Feedback modes recirculate the mixed output; the others store the dry input.
        mem_wdata   = (mode_q[1] && !dly_zero_q) ? y : x_q;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        data_out_d  = {~y[DW-1], y[DW-2:0]};
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      clr_addr_q  <= '0;
      dv_q        <= 1'b0;
      dv_prev_q   <= 1'b0;
      x_q         <= '0;
      mode_q      <= 2'b00;
      gain_q      <= 2'b00;
      dly_zero_q  <= 1'b1;
      data_out_q  <= MIDSCALE;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      clr_addr_q  <= clr_addr_d;
      dv_q        <= dv_d;
      dv_prev_q   <= dv_prev_d;
      x_q         <= x_d;
      mode_q      <= mode_d;
      gain_q      <= gain_d;
      dly_zero_q  <= dly_zero_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Buffer contents are initialised by the CLEAR sweep, so the array itself has no reset.
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[rd_addr_q];
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line: clear, pass-through, feedforward/feedback echoes, saturation/wrap,
// overrun, mid-operation reset and pointer wrap with a small reference model of the delay line.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp); end end

module tb_echo_delay_line;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic       data_valid;
  logic [9:0] delay_sel;
  logic [1:0] mode;
  logic [1:0] gain_shift;
  logic [9:0] data_out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int xh [0:8207];

  echo_delay_line dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .delay_sel  (delay_sel),
    .mode       (mode),
    .gain_shift (gain_shift),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Counts cycles with busy high while pulsing data_valid; flags any output activity.
  task automatic clear_phase(output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    while (busy === 1'b1 && cyc < 9000) begin
      if (out_valid !== 1'b0 || data_out !== 10'd512 || overrun !== 1'b0) bad++;
      data_valid = (cyc < 8000) && (cyc % 5 == 1);
      cyc++;
      tick();
    end
    data_valid = 1'b0;
    repeat (3) begin
      if (out_valid !== 1'b0 || overrun !== 1'b0) bad++;
      tick();
    end
  endtask

  // One sample; ovs = out_valid at E+2, E+3, E+4 (expect 3'b010). Controls are scrambled after acceptance.
  task automatic run_sample(input int din, input logic [1:0] m, input logic [1:0] g, input int ds,
                            output logic [9:0] dout, output logic [2:0] ovs);
    data_in    = 10'(din);
    mode       = m;
    gain_shift = g;
    delay_sel  = 10'(ds);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    mode       = ~m;
    gain_shift = ~g;
    data_in    = ~data_in;
    delay_sel  = ~delay_sel;
    tick();
    ovs[0] = out_valid;
    tick();
    ovs[1] = out_valid;
    dout   = data_out;
    tick();
    ovs[2] = out_valid;
  endtask

  initial begin
    logic [9:0] dout;
    logic [2:0] ovs;
    int cyc, bad, exp_v, pulses, cap;
    int x, d, wbad;
    logic [1:0] g;

    rst_n = 1'b0; data_valid = 1'b0; data_in = 10'd512;
    delay_sel = '0; mode = 2'b00; gain_shift = 2'b00;
    repeat (3) tick();
    `CHK("reset_data_out", data_out, 10'd512)
    `CHK("reset_out_valid", out_valid, 1'b0)
    `CHK("reset_overrun", overrun, 1'b0)
    `CHK("reset_busy", busy, 1'b1)

    rst_n = 1'b1;
    clear_phase(cyc, bad);
    `CHK("clear_cycles", cyc, 8192)
    `CHK("clear_quiet", bad, 0)
    `CHK("busy_low_after_clear", busy, 1'b0)

    // Feedforward, D=8, gain 1/2: impulse then midscale.
    for (int k = 0; k < 10; k++) begin
      run_sample((k == 0) ? 768 : 512, 2'b01, 2'b00, 1, dout, ovs);
      exp_v = (k == 0) ? 768 : (k == 8) ? 640 : 512;
      `CHK("ff_echo", dout, 10'(exp_v))
      if (k == 0) `CHK("ff_valid_pulse", ovs, 3'b010)
    end

    // Feedback subtract, D=8, gain 1/2: alternating decaying echoes.
    for (int k = 0; k < 25; k++) begin
      run_sample((k == 0) ? 768 : 512, 2'b10, 2'b00, 1, dout, ovs);
      exp_v = (k == 0) ? 768 : (k == 8) ? 384 : (k == 16) ? 576 : (k == 24) ? 480 : 512;
      `CHK("fb_sub_echo", dout, 10'(exp_v))
    end

    // Feedback add, D=8, gain 1/4; k=7 and k=15 pick up residue left by the previous run.
    for (int k = 0; k < 17; k++) begin
      run_sample((k == 0) ? 768 : 512, 2'b11, 2'b01, 1, dout, ovs);
      exp_v = (k == 0) ? 768 : (k == 7) ? 504 : (k == 8) ? 576 : (k == 15) ? 510 : (k == 16) ? 528 : 512;
      `CHK("fb_add_echo", dout, 10'(exp_v))
    end

    run_sample(700, 2'b10, 2'b00, 0, dout, ovs);
    `CHK("passthru_d0", dout, 10'd700)
    `CHK("passthru_valid", ovs, 3'b010)
    run_sample(300, 2'b00, 2'b00, 1, dout, ovs);
    `CHK("bypass_mode", dout, 10'd300)

    // Full-scale sample, then its own echo mixed with another full-scale sample.
    run_sample(1023, 2'b01, 2'b00, 1, dout, ovs);
    `CHK("fullscale_dry", dout, 10'd1023)
    for (int k = 0; k < 7; k++) run_sample(512, 2'b01, 2'b00, 1, dout, ovs);
    run_sample(1023, 2'b01, 2'b00, 1, dout, ovs);
`ifdef ECHO_SAT_EN
    `CHK("overflow_result", dout, 10'd1023)
`else
    `CHK("overflow_result", dout, 10'd254)
`endif

    `CHK("no_overrun_at_spacing5", overrun, 1'b0)

    // Two edges two cycles apart.
    data_in = 10'd600; mode = 2'b00; gain_shift = 2'b00; delay_sel = '0;
    data_valid = 1'b1; tick();
    data_valid = 1'b0; tick();
    data_valid = 1'b1; tick();
    data_valid = 1'b0;
    pulses = 0; cap = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) begin pulses++; cap = int'(data_out); end
      tick();
    end
    `CHK("overrun_single_output", pulses, 1)
    `CHK("overrun_first_sample", cap, 600)
    `CHK("overrun_set", overrun, 1'b1)
    run_sample(400, 2'b00, 2'b00, 0, dout, ovs);
    `CHK("after_overrun_sample", dout, 10'd400)
    `CHK("overrun_sticky", overrun, 1'b1)

    // Reset while a sample is in flight.
    data_in = 10'd900; mode = 2'b00; delay_sel = '0;
    data_valid = 1'b1; tick();
    data_valid = 1'b0; tick();
    tick();
    rst_n = 1'b0;
    #1;
    `CHK("midreset_data_out", data_out, 10'd512)
    `CHK("midreset_out_valid", out_valid, 1'b0)
    `CHK("midreset_busy", busy, 1'b1)
    `CHK("midreset_overrun", overrun, 1'b0)
    tick(); tick();
    rst_n = 1'b1;
    clear_phase(cyc, bad);
    `CHK("reclear_cycles", cyc, 8192)
    `CHK("reclear_quiet", bad, 0)

    // Pointer wrap: feedforward D=8 with rotating gain across more than one buffer length.
    wbad = 0;
    for (int i = 0; i < 8208; i++) begin
      x = ((i * 37) % 512) - 256;
      xh[i] = x;
      g = 2'(i % 4);
      d = (i >= 8) ? (xh[i-8] >>> (int'(g) + 1)) : 0;
      exp_v = x + d + 512;
      run_sample(x + 512, 2'b01, g, 1, dout, ovs);
      if (dout !== 10'(exp_v) || ovs !== 3'b010) wbad++;
      if (i >= 8184 && i < 8200) `CHK("wrap_window", dout, 10'(exp_v))
    end
    `CHK("wrap_all_samples", wbad, 0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
